// File: rtl/regfile_wb_sequencer_if.sv
// Bundle between the WB stage, the register file write port and the hazard logic.
// The slave modport is the sequencer's view; the master modport is its environment.
interface regfile_wb_sequencer_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic         in_en1;
  logic [2:0]   in_dst1;
  logic [N-1:0] in_data1;
  logic         in_en2;
  logic [2:0]   in_dst2;
  logic [N-1:0] in_data2;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic [2:0]   q_addr;
  logic         q_hit;
  logic         busy;

  modport master (
    output in_valid, in_en1, in_dst1, in_data1, in_en2, in_dst2, in_data2, q_addr,
    input  in_ready, wr_en, wr_addr, wr_data, q_hit, busy
  );

  modport slave (
    input  in_valid, in_en1, in_dst1, in_data1, in_en2, in_dst2, in_data2, q_addr,
    output in_ready, wr_en, wr_addr, wr_data, q_hit, busy
  );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Queues WB-stage requests (up to two destinations each) and serialises them onto the
// register file's single write port. Optional macro WB_BYPASS_EN: same-cycle write for empty-queue singles.
module regfile_wb_sequencer #(
  parameter int N     = 16,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {P1, P2} phase_t;

  logic         en1_q   [DEPTH];
  logic [2:0]   dst1_q  [DEPTH];
  logic [N-1:0] data1_q [DEPTH];
  logic         en2_q   [DEPTH];
  logic [2:0]   dst2_q  [DEPTH];
  logic [N-1:0] data2_q [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  phase_t        phase;
  phase_t        phase_nxt;

  logic          push;
  logic          pop;
  logic          bypass;
  logic          hd_en;
  logic [2:0]    hd_addr;
  logic [N-1:0]  hd_data;

  // in_ready depends only on the registered count, never on this cycle's pop.
  assign bus.in_ready = (count < CW'(DEPTH));
  assign bus.busy     = (count != '0);
  assign push = bus.in_valid && bus.in_ready && (bus.in_en1 || bus.in_en2) && !bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      en1_q[wr_ptr]   <= bus.in_en1;
      dst1_q[wr_ptr]  <= bus.in_dst1;
      data1_q[wr_ptr] <= bus.in_data1;
      en2_q[wr_ptr]   <= bus.in_en2;
      dst2_q[wr_ptr]  <= bus.in_dst2;
      data2_q[wr_ptr] <= bus.in_data2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= P1;
    else     phase <= phase_nxt;
  end

  // Head decode: P1 issues dst1 (or dst2 if only en2), P2 issues the remaining dst2.
  always_comb begin
    phase_nxt = phase;
    pop       = 1'b0;
    hd_en     = 1'b0;
    hd_addr   = '0;
    hd_data   = '0;
    if (count != '0) begin
      hd_en = 1'b1;
      case (phase)
        P1: begin
          if (en1_q[rd_ptr]) begin
            hd_addr = dst1_q[rd_ptr];
            hd_data = data1_q[rd_ptr];
            if (en2_q[rd_ptr]) phase_nxt = P2;
            else               pop       = 1'b1;
          end else begin
            hd_addr = dst2_q[rd_ptr];
            hd_data = data2_q[rd_ptr];
            pop     = 1'b1;
          end
        end
        P2: begin
          hd_addr   = dst2_q[rd_ptr];
          hd_data   = data2_q[rd_ptr];
          pop       = 1'b1;
          phase_nxt = P1;
        end
        default: phase_nxt = P1;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  assign bypass = (count == '0) && bus.in_valid && (bus.in_en1 ^ bus.in_en2);

  always_comb begin
    bus.wr_en   = hd_en;
    bus.wr_addr = hd_addr;
    bus.wr_data = hd_data;
    if (bypass) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = bus.in_en1 ? bus.in_dst1  : bus.in_dst2;
      bus.wr_data = bus.in_en1 ? bus.in_data1 : bus.in_data2;
    end
  end
`else
  assign bypass      = 1'b0;
  assign bus.wr_en   = hd_en;
  assign bus.wr_addr = hd_addr;
  assign bus.wr_data = hd_data;
`endif

  // The head's dst1 stops counting once P2 is reached; the write in flight still counts.
  always_comb begin
    bus.q_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (en2_q[rd_ptr + AW'(k)] && (dst2_q[rd_ptr + AW'(k)] == bus.q_addr))
          bus.q_hit = 1'b1;
        if (!(k == 0 && phase == P2) && en1_q[rd_ptr + AW'(k)] &&
            (dst1_q[rd_ptr + AW'(k)] == bus.q_addr))
          bus.q_hit = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed bench for regfile_wb_sequencer (default build): reset, single/dual/same-address
// writes, hazard query, backpressure and reset while requests are queued.
module tb_regfile_wb_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_sequencer_if #(.N(16)) bus ();
  regfile_wb_sequencer #(.N(16), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [15:0] rf [8];
  logic [18:0] wlog [$];

  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      rf[bus.wr_addr] <= bus.wr_data;
      wlog.push_back({bus.wr_addr, bus.wr_data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic e1, input logic [2:0] d1, input logic [15:0] v1,
                         input logic e2, input logic [2:0] d2, input logic [15:0] v2);
    bus.in_valid = 1'b1;
    bus.in_en1 = e1; bus.in_dst1 = d1; bus.in_data1 = v1;
    bus.in_en2 = e2; bus.in_dst2 = d2; bus.in_data2 = v2;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_en1 = 1'b0; bus.in_dst1 = '0; bus.in_data1 = '0;
    bus.in_en2 = 1'b0; bus.in_dst2 = '0; bus.in_data2 = '0;
  endtask

  initial begin
    int  base;
    logic acc;
    logic saw_full;

    rst = 1'b1;
    idle();
    bus.q_addr = 3'd0;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_q_hit", bus.q_hit, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick();

    // Single write
    set_req(1'b1, 3'd3, 16'hABCD, 1'b0, 3'd0, 16'h0);
    tick();
    idle();
    chk("single_wr_en", bus.wr_en, 1);
    chk("single_wr_addr", bus.wr_addr, 3);
    chk("single_wr_data", bus.wr_data, 16'hABCD);
    chk("single_busy", bus.busy, 1);
    tick();
    chk("single_idle_wr_en", bus.wr_en, 0);
    chk("single_idle_wr_addr", bus.wr_addr, 0);
    chk("single_idle_wr_data", bus.wr_data, 0);
    chk("single_idle_busy", bus.busy, 0);
    chk("single_rf3", rf[3], 16'hABCD);

    // Dual write
    set_req(1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022);
    tick();
    idle();
    chk("dual_w1_en", bus.wr_en, 1);
    chk("dual_w1_addr", bus.wr_addr, 1);
    chk("dual_w1_data", bus.wr_data, 16'h0011);
    tick();
    chk("dual_w2_en", bus.wr_en, 1);
    chk("dual_w2_addr", bus.wr_addr, 2);
    chk("dual_w2_data", bus.wr_data, 16'h0022);
    chk("dual_w2_busy", bus.busy, 1);
    tick();
    chk("dual_done_wr_en", bus.wr_en, 0);
    chk("dual_done_busy", bus.busy, 0);

    // No-op request is accepted but never enqueued
    set_req(1'b0, 3'd6, 16'h6666, 1'b0, 3'd7, 16'h7777);
    tick();
    idle();
    chk("noop_wr_en", bus.wr_en, 0);
    chk("noop_busy", bus.busy, 0);

    // Same address
    base = wlog.size();
    set_req(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222);
    tick();
    idle();
    tick();
    tick();
    chk("same_count", wlog.size() - base, 2);
    chk("same_first", wlog[base], {3'd5, 16'h1111});
    chk("same_second", wlog[base + 1], {3'd5, 16'h2222});
    chk("same_rf5", rf[5], 16'h2222);

    // Hazard query
    bus.q_addr = 3'd4;
    #1;
    chk("haz_empty", bus.q_hit, 0);
    set_req(1'b1, 3'd4, 16'h0044, 1'b1, 3'd6, 16'h0066);
    tick();
    idle();
    bus.q_addr = 3'd4; #1;
    chk("haz_p1_q4", bus.q_hit, 1);
    bus.q_addr = 3'd6; #1;
    chk("haz_p1_q6", bus.q_hit, 1);
    bus.q_addr = 3'd7; #1;
    chk("haz_p1_q7", bus.q_hit, 0);
    tick();
    bus.q_addr = 3'd4; #1;
    chk("haz_p2_q4", bus.q_hit, 0);
    bus.q_addr = 3'd6; #1;
    chk("haz_p2_q6", bus.q_hit, 1);
    bus.q_addr = 3'd7; #1;
    chk("haz_p2_q7", bus.q_hit, 0);
    tick();
    bus.q_addr = 3'd6; #1;
    chk("haz_popped_q6", bus.q_hit, 0);

    // Backpressure: four dual requests presented back to back
    base = wlog.size();
    saw_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 3'(i), 16'(16'hA000 + i), 1'b1, 3'(i + 4), 16'(16'hB000 + i));
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
        acc = bus.in_ready;
        if (!bus.in_ready) saw_full = 1'b1;
        tick();
      end
      chk("bp_accept", acc, 1);
    end
    idle();
    for (int w = 0; w < 30 && bus.busy; w++) tick();
    chk("bp_drained", bus.busy, 0);
    chk("bp_saw_full", saw_full, 1);
    chk("bp_ready_back", bus.in_ready, 1);
    chk("bp_write_count", wlog.size() - base, 8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_w%0d_dst1", i), wlog[base + 2*i], {3'(i), 16'(16'hA000 + i)});
      chk($sformatf("bp_w%0d_dst2", i), wlog[base + 2*i + 1], {3'(i + 4), 16'(16'hB000 + i)});
    end

    // Reset with two dual requests queued
    set_req(1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202);
    tick();
    set_req(1'b1, 3'd3, 16'h0303, 1'b1, 3'd4, 16'h0404);
    tick();
    idle();
    chk("mid_busy_before", bus.busy, 1);
    chk("mid_full_before", bus.in_ready, 0);
    base = wlog.size();
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", bus.wr_en, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    chk("mid_no_writes", wlog.size() - base, 0);
    chk("mid_after_wr_en", bus.wr_en, 0);
    bus.q_addr = 3'd4; #1;
    chk("mid_after_q_hit", bus.q_hit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
